// File: rtl/order_stream_generator_pkg.sv
// Shared types, constants and helpers for the multi-channel order stream generator.
package order_gen_pkg;

  localparam logic [15:0] SEED_BASE = 16'hACE1;
  localparam logic [15:0] SEED_STEP = 16'h9E37;

  typedef enum logic {IDLE, EMIT} gen_state_e;

  // Fields are sized for the widest supported channel index and price; the top slices them.
  typedef struct packed {
    logic [3:0]  ch;
    logic [15:0] buy;
    logic [15:0] sell;
  } order_beat_t;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [15:0] chan_seed(input int c);
    logic [15:0] cv;
    cv = 16'(c);
    return SEED_BASE ^ (cv * SEED_STEP);
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned w);
    longint unsigned sum;
    longint unsigned limit;
    sum   = longint'(a) + longint'(b);
    limit = (64'd1 << w) - 64'd1;
    return (sum > limit) ? 32'(limit) : 32'(sum);
  endfunction

endpackage

// File: rtl/order_stream_generator_if.sv
// Valid/ready order beat stream from the generator to the matching engine.
interface order_stream_generator_if #(
  parameter int CH_W    = 1,
  parameter int PRICE_W = 8
);
  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_ch;
  logic [PRICE_W-1:0] out_buy;
  logic [PRICE_W-1:0] out_sell;

  modport master (output out_valid, out_ch, out_buy, out_sell, input out_ready);
  modport slave  (input out_valid, out_ch, out_buy, out_sell, output out_ready);
endinterface

// File: rtl/order_stream_generator_lfsr.sv
// One Fibonacci LFSR channel with reseed (priority) and step controls.
module order_lfsr
  import order_gen_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              reseed,
  input  logic [LFSR_W-1:0] reseed_val,
  output logic [LFSR_W-1:0] lfsr,
  output logic [LFSR_W-1:0] lfsr_next
);

  localparam logic [31:0] TAPS = lfsr_taps(LFSR_W);

  logic              fb;
  logic [LFSR_W-1:0] reseed_mix;
  logic [LFSR_W-1:0] reseed_fix;

  // An all-zero state would lock the register, so it is mapped to 1.
  always_comb begin
    fb         = ^(lfsr & TAPS[LFSR_W-1:0]);
    lfsr_next  = {lfsr[LFSR_W-2:0], fb};
    reseed_mix = reseed_val ^ SEED;
    reseed_fix = (reseed_mix == '0) ? LFSR_W'(1) : reseed_mix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (reseed) begin
      lfsr <= reseed_fix;
    end else if (step) begin
      lfsr <= lfsr_next;
    end
  end

endmodule

// File: rtl/order_stream_generator.sv
// Multi-channel pseudo-random order source: tick divider, reseed button, price mapping,
// snapshot-and-emit FSM with overrun tracking.
module order_stream_generator
  import order_gen_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          LFSR_W     = 16,
  parameter int          PRICE_W    = 8,
  parameter int          RAND_BITS  = 5,
  parameter int unsigned BUY_BASE   = 50,
  parameter int unsigned SELL_BASE  = 55,
  parameter int unsigned MIN_SPREAD = 1,
  parameter int          TICK_DIV   = 2000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      gen_en,
  input  logic                      reseed_n,
  order_stream_generator_if.master  os,
  output logic                      overrun,
  output logic [15:0]               drop_count
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int CNT_W = (DIV_W > LFSR_W) ? DIV_W : LFSR_W;

  logic [CNT_W-1:0]  cyc_cnt;
  logic              tick;
  logic [1:0]        sync_q;
  logic              btn_prev;
  logic              reseed_pulse;
  logic [LFSR_W-1:0] lfsr_q    [NUM_CH];
  logic [LFSR_W-1:0] lfsr_next [NUM_CH];
  logic [NUM_CH-1:0] unused_lfsr;
  order_beat_t       price_now [NUM_CH];
  order_beat_t       snap      [NUM_CH];
  order_beat_t       cur;
  logic              unused_beat;
  gen_state_e        state, state_next;
  logic [CH_W-1:0]   idx;
  logic              accept, last_accept, take, drop_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt  <= '0;
      sync_q   <= 2'b11;
      btn_prev <= 1'b1;
    end else begin
      cyc_cnt  <= (cyc_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : cyc_cnt + 1'b1;
      sync_q   <= {sync_q[0], reseed_n};
      btn_prev <= sync_q[1];
    end
  end

  assign tick         = (cyc_cnt == CNT_W'(TICK_DIV - 1));
  assign reseed_pulse = btn_prev & ~sync_q[1];

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    localparam logic [LFSR_W-1:0] SEED_T = LFSR_W'(chan_seed(c));
    localparam logic [LFSR_W-1:0] SEED_C = (SEED_T == '0) ? LFSR_W'(1) : SEED_T;

    order_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED_C)) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .step       (tick && gen_en),
      .reseed     (reseed_pulse),
      .reseed_val (cyc_cnt[LFSR_W-1:0]),
      .lfsr       (lfsr_q[c]),
      .lfsr_next  (lfsr_next[c])
    );

    assign unused_lfsr[c] = ^{lfsr_q[c], lfsr_next[c]};
  end

  // Prices come from the post-step value so a snapshot matches the LFSR state it captures.
  always_comb begin
    int unsigned buy_v, sell_raw, sell_floor;
    buy_v      = 0;
    sell_raw   = 0;
    sell_floor = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      price_now[c] = '0;
      buy_v      = sat_add(BUY_BASE, 32'(lfsr_next[c][RAND_BITS-1:0]), PRICE_W);
      sell_raw   = sat_add(SELL_BASE, 32'(lfsr_next[c][2*RAND_BITS-1:RAND_BITS]), PRICE_W);
      sell_floor = sat_add(buy_v, MIN_SPREAD, PRICE_W);
      price_now[c].ch   = 4'(c);
      price_now[c].buy  = 16'(buy_v);
      price_now[c].sell = 16'((sell_raw > sell_floor) ? sell_raw : sell_floor);
    end
  end

  assign accept      = (state == EMIT) && os.out_ready;
  assign last_accept = accept && (idx == CH_W'(NUM_CH - 1));
  assign take        = tick && gen_en && ((state == IDLE) || last_accept);
  assign drop_evt    = tick && gen_en && (state == EMIT) && !last_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = EMIT;
      EMIT:    if (last_accept) state_next = take ? EMIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cur          = snap[idx];
    os.out_valid = (state == EMIT);
    os.out_ch    = idx;
    os.out_buy   = cur.buy[PRICE_W-1:0];
    os.out_sell  = cur.sell[PRICE_W-1:0];
  end

  assign unused_beat = ^cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      overrun    <= 1'b0;
      drop_count <= '0;
      for (int c = 0; c < NUM_CH; c++) snap[c] <= '0;
    end else begin
      if (take) begin
        idx <= '0;
        for (int c = 0; c < NUM_CH; c++) snap[c] <= price_now[c];
      end else if (accept) begin
        idx <= idx + 1'b1;
      end
      if (drop_evt) begin
        overrun <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_order_stream_generator.sv
// Directed checks of the order stream generator across several parameterisations.
module tb_order_stream_generator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic gen_m = 1'b0, reseed_m = 1'b1;
  logic gen_b = 1'b0, gen_s = 1'b0, gen_z = 1'b0, gen_p = 1'b0;
  logic reseed_z = 1'b1;
  logic overrun_m, overrun_b, overrun_s, overrun_z, overrun_p;
  logic [15:0] drop_m, drop_b, drop_s, drop_z, drop_p;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  order_stream_generator_if #(.CH_W(2), .PRICE_W(8)) os_m ();
  order_stream_generator_if #(.CH_W(1), .PRICE_W(8)) os_b ();
  order_stream_generator_if #(.CH_W(1), .PRICE_W(8)) os_s ();
  order_stream_generator_if #(.CH_W(1), .PRICE_W(8)) os_z ();
  order_stream_generator_if #(.CH_W(1), .PRICE_W(8)) os_p ();

  order_stream_generator #(.NUM_CH(4), .TICK_DIV(4)) dut_m (
    .clk(clk), .reset(reset), .gen_en(gen_m), .reseed_n(reseed_m),
    .os(os_m.master), .overrun(overrun_m), .drop_count(drop_m));

  order_stream_generator #(.NUM_CH(1), .TICK_DIV(4), .MIN_SPREAD(40)) dut_b (
    .clk(clk), .reset(reset), .gen_en(gen_b), .reseed_n(1'b1),
    .os(os_b.master), .overrun(overrun_b), .drop_count(drop_b));

  order_stream_generator #(.NUM_CH(1), .TICK_DIV(4), .BUY_BASE(254)) dut_s (
    .clk(clk), .reset(reset), .gen_en(gen_s), .reseed_n(1'b1),
    .os(os_s.master), .overrun(overrun_s), .drop_count(drop_s));

  order_stream_generator #(.NUM_CH(1), .LFSR_W(8), .RAND_BITS(4), .TICK_DIV(256)) dut_z (
    .clk(clk), .reset(reset), .gen_en(gen_z), .reseed_n(reseed_z),
    .os(os_z.master), .overrun(overrun_z), .drop_count(drop_z));

  order_stream_generator #(.NUM_CH(1), .LFSR_W(8), .RAND_BITS(4), .TICK_DIV(2)) dut_p (
    .clk(clk), .reset(reset), .gen_en(gen_p), .reseed_n(1'b1),
    .os(os_p.master), .overrun(overrun_p), .drop_count(drop_p));

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves time 1 unit after the last reset edge, so cyc_cnt is 0 and counts from here.
  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    gen_m = 1'b1;
    os_m.out_ready = 1'b1;
    do_reset();
    if (os_m.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", os_m.out_valid); end
    checks++;
    if ({os_m.out_ch, os_m.out_buy, os_m.out_sell} !== 18'd0) begin
      errors++; $display("FAIL reset_fields got %0h/%0d/%0d exp 0/0/0", os_m.out_ch, os_m.out_buy, os_m.out_sell);
    end
    checks++;
    if ({overrun_m, drop_m} !== 17'd0) begin errors++; $display("FAIL reset_overrun got %0b/%0d exp 0/0", overrun_m, drop_m); end
    checks++;
    if (dut_m.gen_ch[0].u_lfsr.lfsr !== 16'hACE1) begin
      errors++; $display("FAIL reset_seed got %0h exp ace1", dut_m.gen_ch[0].u_lfsr.lfsr);
    end
    checks++;
  endtask

  task automatic test_basic();
    logic [1:0] exp_ch [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] exp_buy [4] = '{8'd53, 8'd62, 8'd80, 8'd59};
    logic [7:0] exp_sell [4] = '{8'd69, 8'd68, 8'd81, 8'd60};
    gen_m = 1'b1;
    os_m.out_ready = 1'b1;
    do_reset();
    cycles(3);
    if (os_m.out_valid !== 1'b0) begin errors++; $display("FAIL pre_tick_valid got %0b exp 0", os_m.out_valid); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      if ({os_m.out_valid, os_m.out_ch, os_m.out_buy, os_m.out_sell} !== {1'b1, exp_ch[i], exp_buy[i], exp_sell[i]}) begin
        errors++;
        $display("FAIL basic_beat%0d got v%0b ch%0d %0d/%0d exp v1 ch%0d %0d/%0d", i, os_m.out_valid,
                 os_m.out_ch, os_m.out_buy, os_m.out_sell, exp_ch[i], exp_buy[i], exp_sell[i]);
      end
      checks++;
    end
    cycles(1);
    if ({os_m.out_valid, os_m.out_ch, os_m.out_buy, os_m.out_sell, overrun_m} !== {1'b1, 2'd0, 8'd57, 8'd83, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back got v%0b ch%0d %0d/%0d ovr%0b exp v1 ch0 57/83 ovr0", os_m.out_valid,
               os_m.out_ch, os_m.out_buy, os_m.out_sell, overrun_m);
    end
    checks++;
  endtask

  task automatic test_price_clamp();
    gen_b = 1'b1;
    gen_s = 1'b1;
    os_b.out_ready = 1'b1;
    os_s.out_ready = 1'b1;
    do_reset();
    cycles(4);
    if ({os_b.out_valid, os_b.out_buy, os_b.out_sell} !== {1'b1, 8'd53, 8'd93}) begin
      errors++; $display("FAIL min_spread got v%0b %0d/%0d exp v1 53/93", os_b.out_valid, os_b.out_buy, os_b.out_sell);
    end
    checks++;
    if ({os_s.out_valid, os_s.out_ch, os_s.out_buy, os_s.out_sell} !== {1'b1, 1'b0, 8'd255, 8'd255}) begin
      errors++; $display("FAIL saturate got v%0b ch%0d %0d/%0d exp v1 ch0 255/255", os_s.out_valid,
                         os_s.out_ch, os_s.out_buy, os_s.out_sell);
    end
    checks++;
    gen_b = 1'b0;
    gen_s = 1'b0;
  endtask

  task automatic test_stall_overrun();
    gen_m = 1'b1;
    os_m.out_ready = 1'b0;
    do_reset();
    cycles(7);
    if ({os_m.out_valid, os_m.out_ch, os_m.out_buy, os_m.out_sell, drop_m} !== {1'b1, 2'd0, 8'd53, 8'd69, 16'd0}) begin
      errors++; $display("FAIL stall_hold got v%0b ch%0d %0d/%0d drop%0d exp v1 ch0 53/69 drop0", os_m.out_valid,
                         os_m.out_ch, os_m.out_buy, os_m.out_sell, drop_m);
    end
    checks++;
    cycles(6);
    if ({os_m.out_valid, os_m.out_ch, os_m.out_buy, os_m.out_sell} !== {1'b1, 2'd0, 8'd53, 8'd69}) begin
      errors++; $display("FAIL stall_hold_late got v%0b ch%0d %0d/%0d exp v1 ch0 53/69", os_m.out_valid,
                         os_m.out_ch, os_m.out_buy, os_m.out_sell);
    end
    checks++;
    if ({overrun_m, drop_m} !== {1'b1, 16'd2}) begin
      errors++; $display("FAIL overrun_count got %0b/%0d exp 1/2", overrun_m, drop_m);
    end
    checks++;
    if (dut_m.gen_ch[0].u_lfsr.lfsr !== 16'h670F) begin
      errors++; $display("FAIL overrun_steps got %0h exp 670f", dut_m.gen_ch[0].u_lfsr.lfsr);
    end
    checks++;
    os_m.out_ready = 1'b1;
    cycles(1);
    if ({os_m.out_ch, os_m.out_buy, os_m.out_sell} !== {2'd1, 8'd62, 8'd68}) begin
      errors++; $display("FAIL drain_ch1 got ch%0d %0d/%0d exp ch1 62/68", os_m.out_ch, os_m.out_buy, os_m.out_sell);
    end
    checks++;
    cycles(2);
    if ({os_m.out_ch, os_m.out_buy, os_m.out_sell, drop_m} !== {2'd3, 8'd59, 8'd60, 16'd3}) begin
      errors++; $display("FAIL drain_ch3 got ch%0d %0d/%0d drop%0d exp ch3 59/60 drop3", os_m.out_ch,
                         os_m.out_buy, os_m.out_sell, drop_m);
    end
    checks++;
    cycles(1);
    if (os_m.out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got %0b exp 0", os_m.out_valid); end
    checks++;
  endtask

  task automatic test_gen_disable();
    gen_m = 1'b0;
    os_m.out_ready = 1'b1;
    do_reset();
    cycles(9);
    if ({os_m.out_valid, drop_m, dut_m.gen_ch[0].u_lfsr.lfsr} !== {1'b0, 16'd0, 16'hACE1}) begin
      errors++; $display("FAIL gen_disable got v%0b drop%0d lfsr%0h exp v0 drop0 ace1", os_m.out_valid,
                         drop_m, dut_m.gen_ch[0].u_lfsr.lfsr);
    end
    checks++;
  endtask

  task automatic test_reseed_and_reset();
    gen_m = 1'b1;
    os_m.out_ready = 1'b1;
    do_reset();
    cycles(1);
    reseed_m = 1'b0;
    cycles(3);
    if ({dut_m.gen_ch[0].u_lfsr.lfsr, dut_m.gen_ch[1].u_lfsr.lfsr} !== {16'hACE2, 16'h32D5}) begin
      errors++; $display("FAIL reseed_value got %0h/%0h exp ace2/32d5", dut_m.gen_ch[0].u_lfsr.lfsr,
                         dut_m.gen_ch[1].u_lfsr.lfsr);
    end
    checks++;
    if ({os_m.out_valid, os_m.out_buy, os_m.out_sell} !== {1'b1, 8'd53, 8'd69}) begin
      errors++; $display("FAIL reseed_snapshot got v%0b %0d/%0d exp v1 53/69", os_m.out_valid, os_m.out_buy, os_m.out_sell);
    end
    checks++;
    reseed_m = 1'b1;
    cycles(1);
    if (dut_m.gen_ch[0].u_lfsr.lfsr !== 16'hACE2) begin
      errors++; $display("FAIL reseed_single got %0h exp ace2", dut_m.gen_ch[0].u_lfsr.lfsr);
    end
    checks++;
    reset = 1'b1;
    cycles(1);
    if ({os_m.out_valid, os_m.out_ch, overrun_m, drop_m, dut_m.gen_ch[0].u_lfsr.lfsr} !== {1'b0, 2'd0, 1'b0, 16'd0, 16'hACE1}) begin
      errors++; $display("FAIL mid_reset got v%0b ch%0d ovr%0b drop%0d lfsr%0h exp v0 ch0 ovr0 drop0 ace1",
                         os_m.out_valid, os_m.out_ch, overrun_m, drop_m, dut_m.gen_ch[0].u_lfsr.lfsr);
    end
    checks++;
    if (dut_m.cyc_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d exp 0", dut_m.cyc_cnt); end
    checks++;
    reset = 1'b0;
    gen_m = 1'b0;
  endtask

  // 8-bit seed for channel 0 is 0xE1, so a press landing on cyc_cnt 225 would produce zero.
  task automatic test_reseed_zero();
    gen_z = 1'b0;
    os_z.out_ready = 1'b1;
    do_reset();
    cycles(223);
    reseed_z = 1'b0;
    cycles(3);
    if (dut_z.gen_ch[0].u_lfsr.lfsr !== 8'h01) begin
      errors++; $display("FAIL reseed_zero got %0h exp 01", dut_z.gen_ch[0].u_lfsr.lfsr);
    end
    checks++;
    reseed_z = 1'b1;
  endtask

  task automatic test_period();
    int n;
    bit zero_seen;
    gen_p = 1'b1;
    os_p.out_ready = 1'b1;
    do_reset();
    n = 0;
    zero_seen = 1'b0;
    do begin
      cycles(1);
      n++;
      if (dut_p.gen_ch[0].u_lfsr.lfsr == 8'h00) zero_seen = 1'b1;
    end while ((dut_p.gen_ch[0].u_lfsr.lfsr != 8'hE1 || n < 2) && n < 600);
    if (n !== 510) begin errors++; $display("FAIL lfsr8_period got %0d cycles exp 510", n); end
    checks++;
    if (zero_seen !== 1'b0) begin errors++; $display("FAIL lfsr8_zero got %0b exp 0", zero_seen); end
    checks++;
    gen_p = 1'b0;
  endtask

  initial begin
    os_m.out_ready = 1'b1;
    os_b.out_ready = 1'b1;
    os_s.out_ready = 1'b1;
    os_z.out_ready = 1'b1;
    os_p.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_price_clamp();
    test_stall_overrun();
    test_gen_disable();
    test_reseed_and_reset();
    test_reseed_zero();
    test_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
